// File: rtl/interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : interval_meter
// Description : Measures cycles from an accepted start to the next evt rise,
//               compares against EXPECT, saturates/flags overflow, holds result
//               until ack.
// Revision    : 1.0 - initial release
// ============================================================================
module interval_meter #(
    parameter int WIDTH  = 4,
    parameter int EXPECT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             evt,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             overflow
);

    localparam logic [1:0]       c_IDLE   = 2'd0;
    localparam logic [1:0]       c_COUNT  = 2'd1;
    localparam logic [1:0]       c_HOLD   = 2'd2;
    localparam logic [WIDTH-1:0] c_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   c_EXPECT = (WIDTH+1)'(EXPECT);

    if (EXPECT < 1 || EXPECT > (2**WIDTH) - 1) begin : g_expect_range_check
        $error("interval_meter: EXPECT out of range 1..2**WIDTH-1");
    end

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_evt_d;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_count;
    logic             r_match;
    logic             r_overflow;

    logic             w_rise;
    logic [WIDTH:0]   w_cnt_inc;

    assign w_rise    = evt & ~r_evt_d;
    // One extra bit so the EXPECT compare sees the true k; saturation keeps it from wrapping.
    assign w_cnt_inc = {1'b0, r_cnt} + {{WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_evt_d    <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_count    <= '0;
            r_match    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_evt_d <= evt;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state    <= c_COUNT;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_count    <= '0;
                        r_match    <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                c_COUNT: begin
                    if (start) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_MAX) begin
                        r_state    <= c_HOLD;
                        r_busy     <= 1'b0;
                        r_valid    <= 1'b1;
                        r_count    <= c_MAX;
                        r_match    <= 1'b0;
                        r_overflow <= 1'b1;
                    end else if (w_rise) begin
                        r_state    <= c_HOLD;
                        r_busy     <= 1'b0;
                        r_valid    <= 1'b1;
                        r_count    <= w_cnt_inc[WIDTH-1:0];
                        r_match    <= (w_cnt_inc == c_EXPECT);
                        r_overflow <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc[WIDTH-1:0];
                    end
                end
                c_HOLD: begin
                    // start is deliberately ignored here; a new run must begin from IDLE.
                    if (ack) begin
                        r_state <= c_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign count    = r_count;
    assign match    = r_match;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
